// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: a DIGIT-bit ripple slice of add_1b cells is
// reused once per clock to build a WIDTH-bit result with carry/overflow/zero flags.

module add_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_sub_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("add_sub_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] sum_dig;
    logic [DIGIT:0]   cc;
    logic [WIDTH-1:0] z_next;
    logic             last;

    // Select the current digit and merge its sum into the result word.
    always_comb begin
        a_dig  = a_reg[cnt*DIGIT +: DIGIT];
        b_dig  = b_reg[cnt*DIGIT +: DIGIT];
        z_next = z;
        z_next[cnt*DIGIT +: DIGIT] = sum_dig;
        last   = (cnt == CW'(NDIG - 1));
    end

    assign cc[0] = carry;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_slice
            add_1b u_bit (
                .a  (a_dig[i]),
                .b  (b_dig[i]),
                .ci (cc[i]),
                .s  (sum_dig[i]),
                .co (cc[i+1])
            );
        end
    endgenerate

    // Subtraction is A + ~B + 1; an accept is possible from IDLE or DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            z     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= src0;
                        b_reg <= sub ? ~src1 : src1;
                        carry <= sub ? 1'b1 : c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    z     <= z_next;
                    carry <= cc[DIGIT];
                    if (last) begin
                        c_out <= cc[DIGIT];
                        ovf   <= cc[DIGIT-1] ^ cc[DIGIT];
                        zero  <= (z_next == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial: a 32-bit/4-bit-digit instance and a
// 1-bit instance checked against hand-computed results and handshake timing.

module tb_add_sub_serial;
    logic        clk;
    logic        rst;

    logic        start;
    logic        sub;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [31:0] z;
    logic        c_out;
    logic        ovf;
    logic        zero;

    logic        start1;
    logic        sub1;
    logic [0:0]  src0_1;
    logic [0:0]  src1_1;
    logic        c_in1;
    logic        busy1;
    logic        done1;
    logic [0:0]  z1;
    logic        c_out1;
    logic        ovf1;
    logic        zero1;

    int total = 0;
    int bad   = 0;

    add_sub_serial #(.WIDTH(32), .DIGIT(4)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .src0  (src0),
        .src1  (src1),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .c_out (c_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    add_sub_serial #(.WIDTH(1), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .sub   (sub1),
        .src0  (src0_1),
        .src1  (src1_1),
        .c_in  (c_in1),
        .busy  (busy1),
        .done  (done1),
        .z     (z1),
        .c_out (c_out1),
        .ovf   (ovf1),
        .zero  (zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until the selected instance raises done, with a hard bound.
    task automatic wait_done(input bit narrow, output int n);
        n = 0;
        while (((narrow ? done1 : done) !== 1'b1) && n < 40) begin
            step();
            n++;
        end
    endtask

    // Operands are scrambled right after the accepting edge; the result must not care.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic s);
        start = 1'b1;
        src0  = a;
        src1  = b;
        c_in  = cin;
        sub   = s;
        step();
        start = 1'b0;
        src0  = ~a;
        src1  = ~b;
        c_in  = ~cin;
        sub   = ~s;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] ez, input logic ec,
                                 input logic eo, input logic ezr, input int elat);
        int n;
        wait_done(1'b0, n);
        check_output({tag, "_latency"}, n, elat);
        check_output({tag, "_z"}, z, ez);
        check_output({tag, "_c_out"}, {31'd0, c_out}, {31'd0, ec});
        check_output({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        check_output({tag, "_zero"}, {31'd0, zero}, {31'd0, ezr});
        check_output({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_done_drop(input string tag);
        step();
        check_output({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        logic [1:0] fa_tbl [8];
        fa_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst = 1'b1;
        start = 1'b0; sub = 1'b0; src0 = '0; src1 = '0; c_in = 1'b0;
        start1 = 1'b0; sub1 = 1'b0; src0_1 = '0; src1_1 = '0; c_in1 = 1'b0;
        step();
        step();
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_z", z, 32'd0);
        check_output("reset_flags", {29'd0, c_out, ovf, zero}, 32'd0);
        check_output("reset_w1", {27'd0, busy1, done1, z1, c_out1, zero1}, 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] add carry wrap to zero");
        apply_stimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check_output("t1_busy", {31'd0, busy}, 32'd1);
        expect_result("t1", 32'h0000_0000, 1'b1, 1'b0, 1'b1, 8);
        expect_done_drop("t1");

        $display("[TB] add signed overflow");
        apply_stimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        step();
        check_output("t2_flags_hold", {30'd0, c_out, zero}, 32'd3);
        expect_result("t2", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 7);
        expect_done_drop("t2");

        $display("[TB] add with carry-in");
        apply_stimulus(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
        expect_result("t2b", 32'h0000_0004, 1'b0, 1'b0, 1'b0, 8);
        expect_done_drop("t2b");

        $display("[TB] subtraction");
        apply_stimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        expect_result("t3a", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 8);
        expect_done_drop("t3a");
        apply_stimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        expect_result("t3b", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 8);
        expect_done_drop("t3b");
        apply_stimulus(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1);
        expect_result("t3c", 32'h0000_0007, 1'b1, 1'b0, 1'b0, 8);
        expect_done_drop("t3c");

        $display("[TB] start during RUN, then back-to-back");
        apply_stimulus(32'd3, 32'd4, 1'b0, 1'b0);
        step();
        step();
        start = 1'b1; src0 = 32'd100; src1 = 32'd200;
        step();
        start = 1'b0;
        expect_result("t4a", 32'd7, 1'b0, 1'b0, 1'b0, 5);
        start = 1'b1; src0 = 32'd9; src1 = 32'd1; c_in = 1'b0; sub = 1'b0;
        step();
        start = 1'b0;
        check_output("t4_b2b_done_low", {31'd0, done}, 32'd0);
        check_output("t4_b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(1'b0, n);
        check_output("t4_done_gap", n + 1, 32'd9);
        check_output("t4b_z", z, 32'd10);
        expect_done_drop("t4b");

        $display("[TB] reset mid-operation");
        apply_stimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        expect_result("t5pre", 32'h0000_0000, 1'b1, 1'b0, 1'b1, 8);
        expect_done_drop("t5pre");
        apply_stimulus(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("t5_busy", {31'd0, busy}, 32'd0);
        check_output("t5_done", {31'd0, done}, 32'd0);
        check_output("t5_z", z, 32'd0);
        check_output("t5_flags", {29'd0, c_out, ovf, zero}, 32'd0);
        seen = 0;
        repeat (12) begin
            step();
            if (done === 1'b1) seen++;
        end
        check_output("t5_no_late_done", seen, 32'd0);
        apply_stimulus(32'd3, 32'd4, 1'b0, 1'b0);
        expect_result("t5post", 32'd7, 1'b0, 1'b0, 1'b0, 8);
        expect_done_drop("t5post");

        $display("[TB] W1/D1 full-adder table");
        for (int i = 0; i < 8; i++) begin
            start1 = 1'b1;
            src0_1 = i[2];
            src1_1 = i[1];
            c_in1  = i[0];
            sub1   = 1'b0;
            step();
            start1 = 1'b0;
            check_output($sformatf("w1_%0d_busy", i), {31'd0, busy1}, 32'd1);
            wait_done(1'b1, n);
            check_output($sformatf("w1_%0d_latency", i), n, 32'd1);
            check_output($sformatf("w1_%0d_sum", i), {30'd0, c_out1, z1}, {30'd0, fa_tbl[i]});
            check_output($sformatf("w1_%0d_ovf", i), {31'd0, ovf1}, {31'd0, fa_tbl[i][1] ^ i[0]});
            check_output($sformatf("w1_%0d_zero", i), {31'd0, zero1}, {31'd0, ~fa_tbl[i][0]});
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
